// File: rtl/decode38_pkg.sv
// Shared types and helpers for the 3-to-8 LED display decoder.
package decode38_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned LED_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } entry_t;

    // Disabled entries render as a blank slot rather than LED 0.
    function automatic logic [LED_W-1:0] onehot(input entry_t e);
        logic [LED_W-1:0] pat;
        pat = '0;
        if (e.en) begin
            pat = LED_W'(1) << e.code;
        end
        return pat;
    endfunction

endpackage

// File: rtl/decode38_if.sv
// Producer-facing bus of decode38_hold: code entries in, LED pattern and status out.
interface decode38_if
    import decode38_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_en;
    logic              blink;
    logic [LED_W-1:0]  led;
    logic              busy;
    logic [LVL_W-1:0]  level;

    modport master (
        output in_valid,
        output in_code,
        output in_en,
        output blink,
        input  in_ready,
        input  led,
        input  busy,
        input  level
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  in_en,
        input  blink,
        output in_ready,
        output led,
        output busy,
        output level
    );

endinterface

// File: rtl/decode38_fifo.sv
// Small synchronous FIFO of display entries with occupancy count and registered full flag.
module decode38_fifo
    import decode38_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            full_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & (level_q != '0);

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/decode38_hold.sv
// 3-to-8 LED display decoder: buffers {en, code} entries and shows each one-hot for HOLD_CYCLES clocks.
// Optional blinking of the shown pattern is built when DECODE38_BLINK_EN is defined.
module decode38_hold
    import decode38_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BLINK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    decode38_if.slave  bus
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [LED_W-1:0]  pat_q;
    logic [LED_W-1:0]  pat_d;
    logic              busy_q;
    logic              busy_d;
    logic              pop;
    logic              load;
    logic              push;
    entry_t            wdata;
    entry_t            head;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;

    assign push  = bus.in_valid & bus.in_ready;
    assign wdata = {bus.in_en, bus.in_code};

    decode38_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // State register for the display sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
        end
    end

    // Next entry is loaded on the same edge the previous hold expires, so there is no blank gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                end else begin
                    pat_d  = '0;
                    busy_d = 1'b0;
                end
            end
            SHOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    pat_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            pop     = 1'b1;
            pat_d   = onehot(head);
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            busy_d  = 1'b1;
            state_d = SHOW;
        end
    end

`ifdef DECODE38_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt_q;
    logic          phase_q;

    // Blink phase restarts lit on every load and toggles every BLINK_DIV shown cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (load) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (state_q == SHOW) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + BW'(1);
            end
        end
    end

    assign bus.led = pat_q & {LED_W{phase_q | ~bus.blink}};
`else
    logic unused_blink;

    assign unused_blink = bus.blink ^ (BLINK_DIV == 0);
    assign bus.led      = pat_q;
`endif

    assign bus.busy     = busy_q;
    assign bus.level    = level;
    assign bus.in_ready = ~full;

endmodule
